inpass4_frame_config_sync: RTL and testbench

- Four-pin input pass block: external pad signals I0..I3 into fabric outputs O0..O3.
- Per-pin, frame-configured conditioning selects one of four modes: raw pass, registered, 2-FF synchronized, or synchronized rising-edge pulse.
- Sits at the tile's IO boundary, in the opposite direction to the output-pass blocks.
- Configured through the tile's configuration frame bits.

---
 rtl/inpass4_frame_config_sync_pkg.sv | 15 +
 rtl/inpass4_frame_config_sync_if.sv | 12 +
 rtl/inpass4_frame_config_sync_lane.sv | 86 ++++++++
 rtl/inpass4_frame_config_sync.sv | 54 +++++
 tb/tb_inpass4_frame_config_sync.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/inpass4_frame_config_sync_pkg.sv
// Shared constants for the four-pin input pass block: per-pin mode encodings
// and default debounce sizing.
package inpass4_frame_config_sync_pkg;

    localparam int NUM_PINS                = 4;
    localparam int DEFAULT_NO_CONFIG_BITS  = 8;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_DB_CNT_WIDTH    = 4;

    localparam logic [1:0] MODE_PASS  = 2'b00;
    localparam logic [1:0] MODE_REG   = 2'b01;
    localparam logic [1:0] MODE_SYNC  = 2'b10;
    localparam logic [1:0] MODE_PULSE = 2'b11;

endpackage

// File: rtl/inpass4_frame_config_sync_if.sv
// Pin bundle for the input pass block: pad inputs, 2-bit modes per pin and
// conditioned outputs. W is the number of pins carried.
interface inpass4_frame_config_sync_if #(
    parameter int W = 1
);
    logic [W-1:0]   i;
    logic [2*W-1:0] cfg;
    logic [W-1:0]   o;

    modport master (output i, output cfg, input o);
    modport slave  (input i, input cfg, output o);
endinterface

// File: rtl/inpass4_frame_config_sync_lane.sv
// One input pin: capture/sync flops, optional debounce filter (INPASS_DEBOUNCE_EN)
// and the mode-selected output mux.
module inpass_lane
    import inpass4_frame_config_sync_pkg::*;
#(
    parameter int DebounceCycles = DEFAULT_DEBOUNCE_CYCLES,
    parameter int DbCntWidth     = DEFAULT_DB_CNT_WIDTH
) (
    input  logic                      UserCLK,
    input  logic                      UserRST,
    inpass4_frame_config_sync_if.slave pin
);

    if ((DebounceCycles < 2) || (DebounceCycles > 15) ||
        ((DebounceCycles - 1) >= (1 << DbCntWidth))) begin : g_bad_cfg
        $error("inpass_lane: illegal DebounceCycles/DbCntWidth");
    end

    logic r_q, r_d;
    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;
    logic f;
    logic o_c;

    always_comb begin
        r_d  = UserRST ? 1'b0 : pin.i[0];
        s1_d = UserRST ? 1'b0 : pin.i[0];
        s2_d = UserRST ? 1'b0 : s1_q;
        s3_d = UserRST ? 1'b0 : f;
    end

    always_ff @(posedge UserCLK) begin
        r_q  <= r_d;
        s1_q <= s1_d;
        s2_q <= s2_d;
        s3_q <= s3_d;
    end

`ifdef INPASS_DEBOUNCE_EN
    localparam logic [DbCntWidth-1:0] DB_LAST = DbCntWidth'(DebounceCycles - 1);

    logic                  f_q, f_d;
    logic [DbCntWidth-1:0] c_q, c_d;

    // f follows s2 only after s2 has disagreed for DebounceCycles straight cycles
    always_comb begin
        f_d = f_q;
        c_d = c_q;
        if (UserRST) begin
            f_d = 1'b0;
            c_d = '0;
        end else if (s2_q == f_q) begin
            c_d = '0;
        end else if (c_q == DB_LAST) begin
            f_d = s2_q;
            c_d = '0;
        end else begin
            c_d = c_q + 1'b1;
        end
    end

    always_ff @(posedge UserCLK) begin
        f_q <= f_d;
        c_q <= c_d;
    end

    assign f = f_q;
`else
    assign f = s2_q;
`endif

    always_comb begin
        o_c = 1'b0;
        case (pin.cfg)
            MODE_PASS:  o_c = pin.i[0];
            MODE_REG:   o_c = r_q;
            MODE_SYNC:  o_c = f;
            MODE_PULSE: o_c = f & ~s3_q;
            default:    o_c = 1'b0;
        endcase
    end

    assign pin.o = o_c;

endmodule

// File: rtl/inpass4_frame_config_sync.sv
// Four-pin frame-configured input pass: pads I0..I3 to fabric O0..O3, each
// pin conditioned per ConfigBits[2n+1:2n]. Optional debounce: INPASS_DEBOUNCE_EN.
module inpass4_frame_config_sync
    import inpass4_frame_config_sync_pkg::*;
#(
    parameter int NoConfigBits   = DEFAULT_NO_CONFIG_BITS,
    parameter int DebounceCycles = DEFAULT_DEBOUNCE_CYCLES,
    parameter int DbCntWidth     = DEFAULT_DB_CNT_WIDTH
) (
    input  logic                    UserCLK,
    input  logic                    UserRST,
    input  logic                    I0,
    input  logic                    I1,
    input  logic                    I2,
    input  logic                    I3,
    output logic                    O0,
    output logic                    O1,
    output logic                    O2,
    output logic                    O3,
    input  logic [NoConfigBits-1:0] ConfigBits
);

    if (NoConfigBits != 2 * NUM_PINS) begin : g_bad_width
        $error("inpass4_frame_config_sync: NoConfigBits must be 8");
    end

    logic [NUM_PINS-1:0] i_vec;
    logic [NUM_PINS-1:0] o_vec;

    assign i_vec = {I3, I2, I1, I0};

    for (genvar g = 0; g < NUM_PINS; g++) begin : g_lane
        inpass4_frame_config_sync_if #(.W(1)) lif ();

        assign lif.i    = i_vec[g];
        assign lif.cfg  = ConfigBits[2*g +: 2];
        assign o_vec[g] = lif.o[0];

        inpass_lane #(
            .DebounceCycles (DebounceCycles),
            .DbCntWidth     (DbCntWidth)
        ) u_lane (
            .UserCLK (UserCLK),
            .UserRST (UserRST),
            .pin     (lif.slave)
        );
    end

    assign O0 = o_vec[0];
    assign O1 = o_vec[1];
    assign O2 = o_vec[2];
    assign O3 = o_vec[3];

endmodule

// File: tb/tb_inpass4_frame_config_sync.sv
// Directed bench for inpass4_frame_config_sync: expected O vectors are queued
// by the stimulus and checked by an independent monitor process.
module tb_inpass4_frame_config_sync;

`ifdef INPASS_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif

    typedef struct {
        string      name;
        logic [3:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    event chk_ev;

    inpass4_frame_config_sync_if #(.W(4)) pins ();

    inpass4_frame_config_sync #(
        .NoConfigBits   (8),
        .DebounceCycles (4),
        .DbCntWidth     (4)
    ) dut (
        .UserCLK    (clk),
        .UserRST    (rst),
        .I0         (pins.i[0]),
        .I1         (pins.i[1]),
        .I2         (pins.i[2]),
        .I3         (pins.i[3]),
        .O0         (pins.o[0]),
        .O1         (pins.o[1]),
        .O2         (pins.o[2]),
        .O3         (pins.o[3]),
        .ConfigBits (pins.cfg)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(chk_ev);
            while (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (pins.o !== e.exp) begin
                    errors++;
                    $display("FAIL %s: O=%b expected %b at %0t", e.name, pins.o, e.exp, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_o(input string name, input logic [3:0] e);
        exp_t x;
        x.name = name;
        x.exp  = e;
        sb.push_back(x);
        ->chk_ev;
        #1;
    endtask

    initial begin
        logic [3:0] pats_rst [4] = '{4'hA, 4'h5, 4'hF, 4'h3};
        logic [3:0] pats_run [2] = '{4'hC, 4'h6};

        pins.i   = 4'h0;
        pins.cfg = 8'h00;
        rst      = 1'b1;
        repeat (2) tick();

        // Mode 00 follows the pads combinationally, even under reset
        foreach (pats_rst[k]) begin
            pins.i = pats_rst[k];
            #1;
            expect_o("pass_in_rst", pats_rst[k]);
        end
        @(negedge clk) rst = 1'b0;
        tick();
        foreach (pats_run[k]) begin
            #1 pins.i = pats_run[k];
            #1;
            expect_o("pass_run", pats_run[k]);
        end

        // Mode 01: one-edge latency, cleared by reset
        @(negedge clk);
        pins.cfg = 8'h55;
        pins.i   = 4'h0;
        tick();
        expect_o("reg_zero", 4'h0);
        @(negedge clk) pins.i = 4'b0100;
        tick();
        expect_o("reg_rise", 4'b0100);
        pins.i = 4'h0;
        #1;
        expect_o("reg_hold", 4'b0100);
        @(negedge clk);
        pins.i = 4'b0100;
        rst    = 1'b1;
        tick();
        expect_o("reg_rst", 4'h0);
        @(negedge clk) rst = 1'b0;
        tick();
        expect_o("reg_after_rst", 4'b0100);

        // Mode 10: two-edge sync latency (plus debounce when built in)
        @(negedge clk);
        pins.cfg = 8'hAA;
        pins.i   = 4'h0;
        rst      = 1'b1;
        tick();
        expect_o("sync_rst", 4'h0);
        @(negedge clk);
        rst    = 1'b0;
        pins.i = 4'b0010;
        for (int j = 0; j <= DB + 1; j++) begin
            tick();
            expect_o("sync_lat", (j == DB + 1) ? 4'b0010 : 4'b0000);
        end

        // Mode 11: two 6-cycle highs on I3 give exactly two single-cycle pulses
        @(negedge clk);
        pins.cfg = 8'hFF;
        pins.i   = 4'h0;
        rst      = 1'b1;
        tick();
        expect_o("pulse_rst", 4'h0);
        @(negedge clk) rst = 1'b0;
        for (int j = 0; j < 24; j++) begin
            @(negedge clk) pins.i = ((j % 12) < 6) ? 4'b1000 : 4'b0000;
            tick();
            expect_o("pulse_train", ((j % 12) == DB + 1) ? 4'b1000 : 4'b0000);
        end

`ifdef INPASS_DEBOUNCE_EN
        // Short glitch is absorbed; a 4-cycle high gets through
        @(negedge clk);
        pins.cfg = 8'hAA;
        pins.i   = 4'h0;
        rst      = 1'b1;
        tick();
        @(negedge clk) rst = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk) pins.i = (j < 2) ? 4'b0001 : 4'b0000;
            tick();
            expect_o("db_glitch", 4'b0000);
        end
        for (int j = 0; j <= DB + 1; j++) begin
            @(negedge clk) pins.i = (j < 4) ? 4'b0001 : 4'b0000;
            tick();
            expect_o("db_pass", (j == DB + 1) ? 4'b0001 : 4'b0000);
        end
`endif

        // Mode 11 with I0 held high across a 3-cycle reset
        @(negedge clk);
        pins.cfg = 8'hFF;
        pins.i   = 4'b0001;
        rst      = 1'b0;
        repeat (DB + 4) tick();
        @(negedge clk) rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            expect_o("pulse_in_rst", 4'b0000);
        end
        @(negedge clk) rst = 1'b0;
        for (int j = 1; j <= DB + 4; j++) begin
            tick();
            expect_o("pulse_after_rst", (j == DB + 2) ? 4'b0001 : 4'b0000);
        end

        // Switching 10 -> 11 with history already high yields no pulse
        @(negedge clk) pins.cfg = 8'hAA;
        #1;
        expect_o("sync_high", 4'b0001);
        pins.cfg = 8'hFF;
        #1;
        expect_o("switch_no_pulse", 4'b0000);
        tick();
        expect_o("switch_no_pulse_next", 4'b0000);

        #5;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
